// File: rtl/tick_send_arbiter_pkg.sv
// Shared types and helpers for the multi-channel tick send arbiter.
package tick_send_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        ACK,
        DRAIN
    } state_t;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

    // Index width that never collapses to zero bits for one or two channels.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_send_arbiter_rr.sv
// Combinational channel arbiter: round-robin from ptr, or fixed lowest-index-first.
module rr_arbiter
    import tick_send_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned PRIO_MODE = PRIO_RR
) (
    input  logic [N-1:0]                req,
    input  logic [clog2_min1(N)-1:0]    ptr,
    output logic                        gnt_valid,
    output logic [clog2_min1(N)-1:0]    gnt_idx
);

    localparam int unsigned IDX_W = clog2_min1(N);

    logic [IDX_W-1:0] cand;

    // Scan N candidates starting at ptr (or at 0 in fixed mode); first hit wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (PRIO_MODE == PRIO_FIXED) begin
                cand = IDX_W'(i);
            end else begin
                cand = IDX_W'((32'(ptr) + i) % N);
            end
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tick_send_arbiter.sv
// Captures per-channel tick words, arbitrates them and hands one word at a time to a UART TX.
module tick_send_arbiter
    import tick_send_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter int unsigned PRIO_MODE   = PRIO_RR
) (
    input  logic                            clkIN,
    input  logic                            rstIN,
    input  logic [N_CH-1:0]                 tickIN,
    input  logic [N_CH*DATA_W-1:0]          dataIN,
    input  logic                            nBusyIN,
    output logic                            sendOUT,
    output logic [DATA_W-1:0]               dataOUT,
    output logic [clog2_min1(N_CH)-1:0]     chanOUT,
    output logic [N_CH-1:0]                 ackOUT,
    output logic [N_CH-1:0]                 dropOUT,
    output logic                            timeoutOUT
);

    localparam int unsigned IDX_W = clog2_min1(N_CH);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

    state_t             state;
    logic [N_CH-1:0]    tick_q;
    logic [N_CH-1:0]    pend;
    logic [DATA_W-1:0]  hold [N_CH];
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   ptr;

    logic [N_CH-1:0]    edge_v;
    logic [N_CH-1:0]    clr_v;
    logic [N_CH-1:0]    requeue_v;
    logic               gnt_valid;
    logic [IDX_W-1:0]   gnt_idx;
    logic               grant_fire;
    logic               timeout_fire;
    logic [IDX_W-1:0]   chan_next;

    rr_arbiter #(
        .N         (N_CH),
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .req       (pend),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        edge_v       = tickIN & ~tick_q;
        grant_fire   = (state == IDLE) && nBusyIN && gnt_valid;
        timeout_fire = (state == SEND) && nBusyIN && (cnt == CNT_LAST);
        clr_v        = '0;
        requeue_v    = '0;
        if (grant_fire) begin
            clr_v[gnt_idx] = 1'b1;
        end
        if (timeout_fire) begin
            requeue_v[chanOUT] = 1'b1;
        end
        chan_next = (chanOUT == IDX_LAST) ? '0 : chanOUT + IDX_W'(1);
    end

    always_ff @(posedge clkIN) begin
        if (rstIN) begin
            state      <= IDLE;
            tick_q     <= '0;
            pend       <= '0;
            cnt        <= '0;
            ptr        <= '0;
            sendOUT    <= 1'b0;
            dataOUT    <= '0;
            chanOUT    <= '0;
            ackOUT     <= '0;
            dropOUT    <= '0;
            timeoutOUT <= 1'b0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                hold[c] <= '0;
            end
        end else begin
            tick_q     <= tickIN;
            ackOUT     <= '0;
            timeoutOUT <= 1'b0;

            // A set in the grant cycle survives the clear and is not an overrun; a timed-out
            // word being re-queued over a newer (or simultaneous) tick is.
            pend    <= edge_v | requeue_v | (pend & ~clr_v);
            dropOUT <= (edge_v & pend & ~clr_v) | (requeue_v & (edge_v | pend));
            for (int unsigned c = 0; c < N_CH; c++) begin
                if (edge_v[c]) begin
                    hold[c] <= dataIN[c*DATA_W +: DATA_W];
                end
            end

            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        dataOUT <= hold[gnt_idx];
                        chanOUT <= gnt_idx;
                        sendOUT <= 1'b1;
                        cnt     <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (!nBusyIN) begin
                        sendOUT         <= 1'b0;
                        ackOUT[chanOUT] <= 1'b1;
                        state           <= ACK;
                    end else if (timeout_fire) begin
                        sendOUT    <= 1'b0;
                        timeoutOUT <= 1'b1;
                        ptr        <= chan_next;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACK: begin
                    ptr   <= chan_next;
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (nBusyIN) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tick_send_arbiter.sv
// Directed bench for tick_send_arbiter: one round-robin and one fixed-priority instance.
module tb_tick_send_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  tick_r;
    logic [N*DW-1:0] data_r;
    logic          nbusy;
    logic          sel_fx;

    logic          send_rr, send_fx;
    logic [DW-1:0] data_rr, data_fx;
    logic [1:0]    chan_rr, chan_fx;
    logic [N-1:0]  ack_rr, ack_fx, drop_rr, drop_fx;
    logic          to_rr, to_fx;

    logic          obs_send;
    logic [DW-1:0] obs_data;
    logic [1:0]    obs_chan;
    logic [N-1:0]  obs_ack, obs_drop;
    logic          obs_to;

    assign obs_send = sel_fx ? send_fx : send_rr;
    assign obs_data = sel_fx ? data_fx : data_rr;
    assign obs_chan = sel_fx ? chan_fx : chan_rr;
    assign obs_ack  = sel_fx ? ack_fx  : ack_rr;
    assign obs_drop = sel_fx ? drop_fx : drop_rr;
    assign obs_to   = sel_fx ? to_fx   : to_rr;

    tick_send_arbiter #(
        .N_CH(N), .DATA_W(DW), .TIMEOUT_CYC(TO), .PRIO_MODE(0)
    ) dut (
        .clkIN(clk), .rstIN(rst), .tickIN(tick_r), .dataIN(data_r), .nBusyIN(nbusy),
        .sendOUT(send_rr), .dataOUT(data_rr), .chanOUT(chan_rr), .ackOUT(ack_rr),
        .dropOUT(drop_rr), .timeoutOUT(to_rr)
    );

    tick_send_arbiter #(
        .N_CH(N), .DATA_W(DW), .TIMEOUT_CYC(TO), .PRIO_MODE(1)
    ) dut_fx (
        .clkIN(clk), .rstIN(rst), .tickIN(tick_r), .dataIN(data_r), .nBusyIN(nbusy),
        .sendOUT(send_fx), .dataOUT(data_fx), .chanOUT(chan_fx), .ackOUT(ack_fx),
        .dropOUT(drop_fx), .timeoutOUT(to_fx)
    );

    int n_checks = 0;
    int n_errors = 0;

    int log_ch[$];
    int log_dat[$];
    int log_ack[$];
    int drop_n[N];
    int to_n;
    int tx_en;
    int send_hi;
    int busy_left;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; observe outputs 1ns after the edge, then run the TX model:
    // busy 3 observed cycles after sendOUT rises, stays busy 4 cycles.
    task automatic step();
        @(posedge clk);
        #1;
        if (obs_ack != '0) begin
            log_ch.push_back(int'(obs_chan));
            log_dat.push_back(int'(obs_data));
            log_ack.push_back(int'(obs_ack));
        end
        for (int c = 0; c < N; c++) begin
            if (obs_drop[c]) drop_n[c]++;
        end
        if (obs_to) to_n++;
        if (tx_en != 0) begin
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) nbusy = 1'b1;
            end else if (obs_send) begin
                send_hi++;
                if (send_hi == 3) begin
                    nbusy     = 1'b0;
                    busy_left = 4;
                    send_hi   = 0;
                end
            end else begin
                send_hi = 0;
            end
        end
    endtask

    task automatic clear_logs();
        log_ch.delete();
        log_dat.delete();
        log_ack.delete();
        for (int c = 0; c < N; c++) drop_n[c] = 0;
        to_n = 0;
    endtask

    task automatic do_reset();
        tx_en     = 0;
        send_hi   = 0;
        busy_left = 0;
        rst       = 1'b1;
        step();
        rst       = 1'b0;
        clear_logs();
    endtask

    task automatic pulse_tick(input int ch, input logic [7:0] d);
        tick_r[ch]         = 1'b1;
        data_r[ch*DW +: DW] = d;
        step();
        tick_r[ch]         = 1'b0;
    endtask

    task automatic pulse_all();
        tick_r = 4'hF;
        data_r = {8'h13, 8'h12, 8'h11, 8'h10};
        step();
        tick_r = '0;
    endtask

    task automatic wait_acks(input string tag, input int n);
        int k;
        k = 0;
        while (log_ch.size() < n && k < 300) begin
            step();
            k++;
        end
        check(tag, log_ch.size(), n);
    endtask

    task automatic check_log(input string tag, input int idx, input int ch, input int dat);
        int gc, gd, ga;
        gc = (idx < log_ch.size()) ? log_ch[idx]  : -1;
        gd = (idx < log_ch.size()) ? log_dat[idx] : -1;
        ga = (idx < log_ch.size()) ? log_ack[idx] : -1;
        check($sformatf("%s_ch%0d", tag, idx),  gc, ch);
        check($sformatf("%s_dat%0d", tag, idx), gd, dat);
        check($sformatf("%s_ack%0d", tag, idx), ga, 1 << ch);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, k;
        rst    = 1'b1;
        tick_r = '0;
        data_r = '0;
        nbusy  = 1'b1;
        sel_fx = 1'b0;
        tx_en  = 0;
        clear_logs();

        // 1: single transfer on ch2 with exact latency
        do_reset();
        check("rst_send", obs_send, 0);
        check("rst_data", obs_data, 0);
        check("rst_chan", obs_chan, 0);
        check("rst_ack",  obs_ack,  0);
        check("rst_drop", obs_drop, 0);
        check("rst_to",   obs_to,   0);
        nbusy = 1'b1;
        tx_en = 1;
        pulse_tick(2, 8'hA5);
        check("t1_send_early", obs_send, 0);
        step();
        check("t1_send", obs_send, 1);
        check("t1_data", obs_data, 8'hA5);
        check("t1_chan", obs_chan, 2);
        step();
        step();
        check("t1_send_held", obs_send, 1);
        step();
        check("t1_send_drop", obs_send, 0);
        check("t1_ack", obs_ack, 4'b0100);
        step();
        check("t1_ack_clear", obs_ack, 0);
        check("t1_n_acks", log_ch.size(), 1);

        // 2a: round-robin from ptr=0
        do_reset();
        nbusy = 1'b1;
        tx_en = 1;
        pulse_all();
        wait_acks("t2a_acks", 4);
        for (int i = 0; i < 4; i++) check_log("t2a", i, i, 8'h10 + i);

        // 2b: ptr moved to 2 by a ch1 send, then wrap order 2,3,0,1
        clear_logs();
        pulse_tick(1, 8'h21);
        wait_acks("t2b_first", 1);
        pulse_all();
        wait_acks("t2b_acks", 5);
        check_log("t2b", 0, 1, 8'h21);
        check_log("t2b", 1, 2, 8'h12);
        check_log("t2b", 2, 3, 8'h13);
        check_log("t2b", 3, 0, 8'h10);
        check_log("t2b", 4, 1, 8'h11);

        // 2c: fixed priority ignores the pointer
        sel_fx = 1'b1;
        do_reset();
        nbusy = 1'b1;
        tx_en = 1;
        pulse_tick(1, 8'h21);
        wait_acks("t2c_first", 1);
        pulse_all();
        wait_acks("t2c_acks", 5);
        check_log("t2c", 0, 1, 8'h21);
        for (int i = 0; i < 4; i++) check_log("t2c", i + 1, i, 8'h10 + i);
        sel_fx = 1'b0;

        // 3: overrun on ch1 while TX busy
        do_reset();
        nbusy = 1'b1;
        tx_en = 1;
        pulse_tick(0, 8'h50);
        step();
        pulse_tick(1, 8'h11);
        step();
        pulse_tick(1, 8'h22);
        wait_acks("t3_acks", 2);
        for (int i = 0; i < 12; i++) step();
        check("t3_n_acks", log_ch.size(), 2);
        check_log("t3", 0, 0, 8'h50);
        check_log("t3", 1, 1, 8'h22);
        check("t3_drop1", drop_n[1], 1);
        check("t3_drop_other", drop_n[0] + drop_n[2] + drop_n[3], 0);

        // 4: timeout with nBusyIN stuck idle, then release
        do_reset();
        nbusy = 1'b1;
        pulse_tick(3, 8'h3C);
        step();
        check("t4_send_start", obs_send, 1);
        hi = 1;
        k  = 0;
        while (obs_send && k < 20) begin
            step();
            k++;
            if (obs_send) hi++;
        end
        check("t4_send_len", hi, TO);
        check("t4_timeout", obs_to, 1);
        check("t4_no_ack", log_ch.size(), 0);
        step();
        check("t4_timeout_clear", obs_to, 0);
        check("t4_resend", obs_send, 1);
        check("t4_resend_data", obs_data, 8'h3C);
        tx_en = 1;
        wait_acks("t4_acks", 1);
        check_log("t4", 0, 3, 8'h3C);
        check("t4_to_count", to_n, 1);
        check("t4_drop", drop_n[3], 0);

        // 5: ch0 edge in the same cycle ch0 is granted
        do_reset();
        nbusy = 1'b0;
        pulse_tick(0, 8'h01);
        step();
        check("t5_hold_off", obs_send, 0);
        nbusy = 1'b1;
        tick_r[0] = 1'b1;
        data_r[7:0] = 8'h02;
        step();
        tick_r[0] = 1'b0;
        check("t5_send", obs_send, 1);
        check("t5_data", obs_data, 8'h01);
        check("t5_no_drop", obs_drop, 0);
        tx_en = 1;
        wait_acks("t5_acks", 2);
        check_log("t5", 0, 0, 8'h01);
        check_log("t5", 1, 0, 8'h02);
        check("t5_drop_total", drop_n[0], 0);

        // 6: reset while in SEND
        do_reset();
        nbusy = 1'b1;
        pulse_tick(2, 8'h77);
        step();
        check("t6_in_send", obs_send, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_send", obs_send, 0);
        check("t6_ack",  obs_ack,  0);
        check("t6_drop", obs_drop, 0);
        check("t6_to",   obs_to,   0);
        check("t6_data", obs_data, 0);
        check("t6_chan", obs_chan, 0);
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (obs_send || obs_to) hi++;
        end
        check("t6_stays_idle", hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
